// File: rtl/vref_ctrl_seq.sv
// Bandgap reference power-up sequencer: enable, settle wait, glitch-free trim ramp.
// Optional write lock register (addr 3) enabled by defining VREF_CTRL_LOCK_EN.
module vref_ctrl_seq #(
  parameter int          SETTLE_CYCLES = 1000,
  parameter int          STEP_CYCLES   = 16,
  parameter logic [7:0]  TRIM_RST      = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] trim,
  output logic       bg_en,
  output logic       sw1_sel,
  output logic       sw2_sel,
  output logic       ready,
  output logic       busy
);

  localparam int CNT_MAX =
    (SETTLE_CYCLES > STEP_CYCLES) ?
    SETTLE_CYCLES : STEP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LD =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LD =
    CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_OFF,
    S_SETTLE,
    S_RAMP,
    S_READY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      trim_q, trim_d;
  logic [7:0]      target_q, target_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic            bg_en_q, bg_en_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            sw1_q, sw1_d;
  logic            sw2_q, sw2_d;
  logic            wr_ready_q, wr_ready_d;
  logic            wr_acc;
  logic            wr_open;
  logic            en;
  logic            step_up;

`ifdef VREF_CTRL_LOCK_EN
  logic            lock_q, lock_d;
  assign wr_open = ~lock_q;
`else
  assign wr_open = 1'b1;
`endif

  assign wr_acc  = wr_valid & wr_ready_q;
  assign en      = ctrl_q[0];
  assign step_up = (target_q > trim_q);

  // Register file writes
  always_comb begin
    target_d = target_q;
    ctrl_d   = ctrl_q;
`ifdef VREF_CTRL_LOCK_EN
    lock_d   = lock_q;
`endif
    if (wr_acc) begin
      case (wr_addr)
        2'd0: begin
          if (wr_open) target_d = wr_data;
        end
        2'd1: begin
          if (wr_open) ctrl_d = wr_data[2:0];
        end
`ifdef VREF_CTRL_LOCK_EN
        2'd3: begin
          if (wr_data == 8'hA5) lock_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trim_d  = trim_q;
    unique case (state_q)
      S_OFF: begin
        if (en) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_RAMP;
          cnt_d   = STEP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RAMP: begin
        if (!en) begin
          state_d = S_OFF;
        end else if (trim_q == target_q) begin
          state_d = S_READY;
        end else if (cnt_q == '0) begin
          cnt_d = STEP_LD;
          if (step_up && trim_q != 8'hFF)
            trim_d = trim_q + 8'd1;
          else if (!step_up && trim_q != 8'h00)
            trim_d = trim_q - 8'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_READY: begin
        if (!en) begin
          state_d = S_OFF;
        end else if (target_q != trim_q) begin
          state_d = S_RAMP;
          cnt_d   = STEP_LD;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  // Outputs follow the next state so every port is a flop
  always_comb begin
    bg_en_d    = (state_d != S_OFF);
    ready_d    = (state_d == S_READY);
    busy_d     = (state_d == S_SETTLE) |
                 (state_d == S_RAMP);
    wr_ready_d = (state_d != S_SETTLE);
    sw1_d      = ctrl_d[1] & ready_d;
    sw2_d      = ctrl_d[2] & ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      trim_q     <= TRIM_RST;
      target_q   <= TRIM_RST;
      ctrl_q     <= '0;
      bg_en_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      sw1_q      <= 1'b0;
      sw2_q      <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trim_q     <= trim_d;
      target_q   <= target_d;
      ctrl_q     <= ctrl_d;
      bg_en_q    <= bg_en_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      sw1_q      <= sw1_d;
      sw2_q      <= sw2_d;
      wr_ready_q <= wr_ready_d;
    end
  end

`ifdef VREF_CTRL_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  assign trim     = trim_q;
  assign bg_en    = bg_en_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign sw1_sel  = sw1_q;
  assign sw2_sel  = sw2_q;
  assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_vref_ctrl_seq.sv
// Directed scoreboard bench for vref_ctrl_seq (default parameters).
// Expected trim steps are queued on each retarget and popped as trim moves.
module tb_vref_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] trim;
  logic       bg_en;
  logic       sw1_sel;
  logic       sw2_sel;
  logic       ready;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  vref_ctrl_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .trim     (trim),
    .bg_en    (bg_en),
    .sw1_sel  (sw1_sel),
    .sw2_sel  (sw2_sel),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    chk("wr_ready_at_write", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic push_ramp(input logic [7:0] from,
                           input logic [7:0] to);
    logic [7:0] v;
    v = from;
    while (v != to) begin
      v = (to > v) ? v + 8'd1 : v - 8'd1;
      sb.push_back(v);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_trim"}, 32'(trim), 32'h80);
    chk({tag, "_bg_en"}, 32'(bg_en), 0);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 1);
    chk({tag, "_sw1"}, 32'(sw1_sel), 0);
    chk({tag, "_sw2"}, 32'(sw2_sel), 0);
  endtask

  // Waits for one trim change and compares it with the queue head
  task automatic wait_step();
    int n;
    logic [7:0] old;
    logic [7:0] e;
    n = 0;
    old = trim;
    while (n < 64) begin
      tick();
      n++;
      if (trim !== old) break;
    end
    chk("step_gap", 32'(n), 16);
    chk("busy_in_ramp", 32'(busy), 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(trim), 32'(old));
    end else begin
      e = sb.pop_front();
      chk("trim_step", 32'(trim), 32'(e));
    end
  endtask

  task automatic drain(input logic s1, input logic s2);
    while (sb.size() > 0) wait_step();
    chk("ready_at_last_step", 32'(ready), 0);
    tick();
    chk("ready_after_ramp", 32'(ready), 1);
    chk("busy_after_ramp", 32'(busy), 0);
    chk("sw1_after_ramp", 32'(sw1_sel), 32'(s1));
    chk("sw2_after_ramp", 32'(sw2_sel), 32'(s2));
  endtask

  // Called just after the enable write was accepted
  task automatic settle(input bit try_wr);
    int n;
    chk("bg_en_before_fsm", 32'(bg_en), 0);
    tick();
    chk("bg_en_on", 32'(bg_en), 1);
    chk("busy_settle", 32'(busy), 1);
    chk("wr_ready_settle", 32'(wr_ready), 0);
    n = 1;
    while (n < 5000) begin
      if (try_wr && n == 500) begin
        wr_addr  = 2'd0;
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        chk("wr_blocked", 32'(wr_ready), 0);
      end
      tick();
      wr_valid = 1'b0;
      if (wr_ready) break;
      n++;
    end
    chk("settle_len", 32'(n), 1000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_vals("reset");
    rst_n = 1'b1;
    tick();
    reset_vals("post_reset");

    // power-up to 0x84
    wr(2'd0, 8'h84);
    wr(2'd1, 8'h07);
    push_ramp(8'h80, 8'h84);
    settle(1'b0);
    drain(1'b1, 1'b1);

    // retrim down
    wr(2'd0, 8'h82);
    chk("ready_hold_accept_edge", 32'(ready), 1);
    tick();
    chk("ready_drop", 32'(ready), 0);
    chk("sw1_drop", 32'(sw1_sel), 0);
    chk("sw2_drop", 32'(sw2_sel), 0);
    push_ramp(8'h84, 8'h82);
    drain(1'b1, 1'b1);

    // disable mid-ramp
    wr(2'd0, 8'h80);
    tick();
    tick();
    chk("trim_before_disable", 32'(trim), 32'h82);
    wr(2'd1, 8'h00);
    tick();
    chk("dis_bg_en", 32'(bg_en), 0);
    chk("dis_busy", 32'(busy), 0);
    chk("dis_ready", 32'(ready), 0);
    chk("dis_trim", 32'(trim), 32'h82);
    repeat (30) tick();
    chk("dis_trim_hold", 32'(trim), 32'h82);

    // re-enable: full settle, blocked write inside it
    wr(2'd1, 8'h07);
    push_ramp(8'h82, 8'h80);
    settle(1'b1);
    drain(1'b1, 1'b1);
    repeat (40) tick();
    chk("target_unchanged", 32'(trim), 32'h80);
    chk("ready_stays", 32'(ready), 1);

    // top boundary
    wr(2'd0, 8'hFE);
    tick();
    chk("ready_drop_fe", 32'(ready), 0);
    push_ramp(8'h80, 8'hFE);
    drain(1'b1, 1'b1);
    wr(2'd0, 8'hFF);
    tick();
    push_ramp(8'hFE, 8'hFF);
    drain(1'b1, 1'b1);
    repeat (40) tick();
    chk("no_wrap_trim", 32'(trim), 32'hFF);
    chk("no_wrap_ready", 32'(ready), 1);

    // lock sequence
    wr(2'd3, 8'hA5);
    wr(2'd0, 8'h10);
`ifdef VREF_CTRL_LOCK_EN
    repeat (40) tick();
    chk("locked_trim", 32'(trim), 32'hFF);
    chk("locked_ready", 32'(ready), 1);
    chk("locked_busy", 32'(busy), 0);
`else
    tick();
    chk("unlocked_ready_drop", 32'(ready), 0);
    push_ramp(8'hFF, 8'h10);
    drain(1'b1, 1'b1);
`endif

    // async reset mid-cycle
    wr(2'd1, 8'h03);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_vals("held_reset");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
